fft_bfp_frame_adapter: RTL

- Parametrised, streaming post-processor placed directly after the FFT core's source port, in front of downstream convolution/accumulation logic.
- Converts block-floating-point frames (mantissa plus per-frame exponent) into fixed-point samples at a programmable common scale, with rounding and saturation.
- Enforces runtime-configurable frame length with Avalon-ST sop/eop checking and error tagging.
- Buffers output in a FIFO so downstream backpressure never corrupts a frame.

---
 rtl/fft_bfp_frame_adapter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/fft_bfp_frame_adapter.sv
// Block-floating-point to fixed-point frame adapter for the FFT source stream.
// Frame-checking FSM, two-stage scale/saturate pipeline and output FIFO.
module fft_bfp_frame_adapter #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 24,
    parameter int LOG2_N_MAX = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sink_valid,
    output logic             sink_ready,
    input  logic [1:0]       sink_error,
    input  logic             sink_sop,
    input  logic             sink_eop,
    input  logic [IN_W-1:0]  sink_real,
    input  logic [IN_W-1:0]  sink_imag,
    input  logic [5:0]       sink_exp,
    input  logic [3:0]       cfg_log2_len,
    input  logic [6:0]       cfg_bias,
    output logic             source_valid,
    input  logic             source_ready,
    output logic [1:0]       source_error,
    output logic             source_sop,
    output logic             source_eop,
    output logic [OUT_W-1:0] source_real,
    output logic [OUT_W-1:0] source_imag,
    output logic [15:0]      stat_frames,
    output logic [15:0]      stat_errors
);

    localparam int CW = LOG2_N_MAX + 1;
    localparam int W1 = 2 * IN_W + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * OUT_W + 4;
    localparam logic [3:0] LMAX = (LOG2_N_MAX > 15) ? 4'd15 : 4'(LOG2_N_MAX);
    localparam logic signed [W1-1:0] SAT_MAX = W1'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [W1-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, IN_FRAME, DROP} state_t;

    state_t          state_q, state_d;
    logic [5:0]      exp_q, exp_d;
    logic [CW-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic [CW-1:0]   len_new, beat_num;
    logic [3:0]      log2_eff;
    logic            accept, emit, emit_sop, emit_eop, stray;
    logic [1:0]      fsm_err, emit_err;
    logic [5:0]      exp_eff;
    logic signed [7:0] shift_s;

    // Wide intermediate holds value << IN_W without wrap, so saturation sees the true magnitude.
    function automatic logic signed [W1-1:0] scale(input logic signed [IN_W-1:0] v,
                                                   input logic signed [7:0] s);
        logic signed [IN_W:0] ve, half;
        int m;
        m = int'(s);
        if (m >= 0) begin
            if (m > IN_W) m = IN_W;
            return W1'(v) <<< m;
        end
        m = -m;
        if (m > IN_W) m = IN_W;
        ve   = (IN_W+1)'(v);
        half = (IN_W+1)'(1) << (m - 1);
        return W1'((ve + half) >>> m);
    endfunction

    function automatic logic [OUT_W-1:0] sat(input logic signed [W1-1:0] x);
        if (x > SAT_MAX) return SAT_MAX[OUT_W-1:0];
        if (x < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        return x[OUT_W-1:0];
    endfunction

    assign accept   = sink_valid & sink_ready;
    assign log2_eff = (cfg_log2_len > LMAX) ? LMAX : cfg_log2_len;
    assign len_new  = CW'(1) << log2_eff;
    assign beat_num = cnt_q + CW'(1);
    assign exp_eff  = (state_q == IDLE) ? sink_exp : exp_q;
    assign shift_s  = $signed({cfg_bias[6], cfg_bias}) - $signed({{2{exp_eff[5]}}, exp_eff});
    assign emit_err = fsm_err | sink_error;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        emit     = 1'b0;
        emit_sop = 1'b0;
        emit_eop = 1'b0;
        fsm_err  = 2'b00;
        stray    = 1'b0;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (sink_sop) begin
                        emit     = 1'b1;
                        emit_sop = 1'b1;
                        exp_d    = sink_exp;
                        len_d    = len_new;
                        cnt_d    = CW'(1);
                        if (len_new == CW'(1)) begin
                            emit_eop = 1'b1;
                            if (!sink_eop) begin
                                fsm_err = 2'b10;
                                state_d = DROP;
                            end
                        end else if (sink_eop) begin
                            emit_eop = 1'b1;
                            fsm_err  = 2'b11;
                        end else begin
                            state_d = IN_FRAME;
                        end
                    end else begin
                        stray = 1'b1;
                    end
                end
                IN_FRAME: begin
                    emit = 1'b1;
                    if (beat_num == len_q) begin
                        emit_eop = 1'b1;
                        fsm_err  = sink_eop ? 2'b00 : 2'b10;
                        state_d  = sink_eop ? IDLE : DROP;
                    end else if (sink_eop) begin
                        emit_eop = 1'b1;
                        fsm_err  = 2'b11;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = beat_num;
                    end
                end
                DROP: begin
                    if (sink_eop) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic                    s1_valid, s1_sop, s1_eop;
    logic [1:0]              s1_err;
    logic signed [W1-1:0]    s1_re, s1_im;
    logic                    s2_valid, s2_sop, s2_eop;
    logic [1:0]              s2_err;
    logic [OUT_W-1:0]        s2_re, s2_im;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             fifo_cnt, fifo_cnt_d;
    logic                    push, pop;
    logic [EW-1:0]           rd_entry;
    logic [EW-1:0]           mem [FIFO_DEPTH];
    int                      room;

    assign push         = s2_valid;
    assign source_valid = (fifo_cnt != '0);
    assign pop          = source_valid & source_ready;
    assign fifo_cnt_d   = fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
    // Room counts beats already committed to the pipeline, so an accepted beat always finds a slot.
    assign room         = FIFO_DEPTH - int'(fifo_cnt_d) - int'(accept & emit) - int'(s1_valid);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            len_q       <= CW'(1);
            cnt_q       <= '0;
            sink_ready  <= 1'b0;
            stat_frames <= '0;
            stat_errors <= '0;
            s1_valid    <= 1'b0;
            s1_sop      <= 1'b0;
            s1_eop      <= 1'b0;
            s1_err      <= '0;
            s1_re       <= '0;
            s1_im       <= '0;
            s2_valid    <= 1'b0;
            s2_sop      <= 1'b0;
            s2_eop      <= 1'b0;
            s2_err      <= '0;
            s2_re       <= '0;
            s2_im       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            sink_ready <= (room >= 3);
            if (emit && emit_eop && emit_err == 2'b00 && stat_frames != 16'hFFFF)
                stat_frames <= stat_frames + 16'd1;
            if ((stray || (emit && emit_err != 2'b00)) && stat_errors != 16'hFFFF)
                stat_errors <= stat_errors + 16'd1;

            s1_valid <= accept & emit;
            s1_sop   <= emit_sop;
            s1_eop   <= emit_eop;
            s1_err   <= emit_err;
            s1_re    <= scale(sink_real, shift_s);
            s1_im    <= scale(sink_imag, shift_s);

            s2_valid <= s1_valid;
            s2_sop   <= s1_sop;
            s2_eop   <= s1_eop;
            s2_err   <= s1_err;
            s2_re    <= sat(s1_re);
            s2_im    <= sat(s1_im);

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt_d;
        end
    end

    // NOTE: FIFO storage has no reset; stale entries are never visible because outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s2_err, s2_sop, s2_eop, s2_im, s2_re};
    end

    assign rd_entry     = mem[rd_ptr];
    assign source_real  = source_valid ? rd_entry[OUT_W-1:0]         : '0;
    assign source_imag  = source_valid ? rd_entry[2*OUT_W-1:OUT_W]   : '0;
    assign source_eop   = source_valid ? rd_entry[2*OUT_W]           : 1'b0;
    assign source_sop   = source_valid ? rd_entry[2*OUT_W+1]         : 1'b0;
    assign source_error = source_valid ? rd_entry[2*OUT_W+3:2*OUT_W+2] : 2'b00;

endmodule
